// File: rtl/prbs_gen_chk.sv
// Fibonacci-LFSR PRBS generator plus a self-synchronising checker that seeds from the
// received stream, verifies a run of predicted words, then flywheels while counting bit errors.
module prbs_gen_chk #(
   parameter int unsigned     WIDTH      = 7,
   parameter logic [WIDTH-1:0] TAPS      = 7'h60,
   parameter int unsigned     DATA_W     = 8,
   parameter int unsigned     LOCK_WORDS = 4,
   parameter int unsigned     LOSS_WORDS = 3,
   parameter int unsigned     ERR_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seed_load,
   input  logic [WIDTH-1:0]  seed,
   input  logic              gen_en,
   output logic [DATA_W-1:0] gen_data,
   output logic              gen_valid,
   input  logic              chk_valid,
   input  logic [DATA_W-1:0] chk_data,
   input  logic              err_clr,
   output logic              locked,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_cnt
);

   localparam int unsigned SUM_W        = ERR_W + 8;
   localparam logic [7:0]  SEED_WORDS_C = 8'((WIDTH + DATA_W - 1) / DATA_W);
   localparam logic [7:0]  LOCK_C       = 8'(LOCK_WORDS);
   localparam logic [7:0]  LOSS_C       = 8'(LOSS_WORDS);

   typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} chk_st_e;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], ^(s & TAPS)};
   endfunction

   function automatic logic [WIDTH-1:0] lfsr_adv(input logic [WIDTH-1:0] s_in);
      logic [WIDTH-1:0] s;
      s = s_in;
      for (int unsigned i = 0; i < DATA_W; i++) s = lfsr_step(s);
      return s;
   endfunction

   // The newest state bit is the bit just produced, so bit 0 carries the output.
   function automatic logic [DATA_W-1:0] lfsr_word(input logic [WIDTH-1:0] s_in);
      logic [WIDTH-1:0]  s;
      logic [DATA_W-1:0] w;
      s = s_in;
      w = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         s = lfsr_step(s);
         w[DATA_W-1-i] = s[0];
      end
      return w;
   endfunction

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s_in,
                                                 input logic [DATA_W-1:0] d);
      logic [WIDTH-1:0] s;
      s = s_in;
      for (int unsigned i = 0; i < DATA_W; i++) s = {s[WIDTH-2:0], d[DATA_W-1-i]};
      return s;
   endfunction

   function automatic logic [6:0] popcnt(input logic [DATA_W-1:0] v);
      logic [6:0] c;
      c = '0;
      for (int unsigned i = 0; i < DATA_W; i++) c = c + 7'(v[i]);
      return c;
   endfunction

   logic [WIDTH-1:0]  gen_state_q, gen_state_d;
   logic [DATA_W-1:0] gen_data_q, gen_data_d;
   logic              gen_valid_q, gen_valid_d;

   always_comb begin
      gen_state_d = gen_state_q;
      gen_data_d  = gen_data_q;
      gen_valid_d = 1'b0;
      if (seed_load) begin
         gen_state_d = (seed == '0) ? '1 : seed;
      end else if (gen_en) begin
         gen_state_d = lfsr_adv(gen_state_q);
         gen_data_d  = lfsr_word(gen_state_q);
         gen_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gen_state_q <= '1;
         gen_data_q  <= '0;
         gen_valid_q <= 1'b0;
      end else begin
         gen_state_q <= gen_state_d;
         gen_data_q  <= gen_data_d;
         gen_valid_q <= gen_valid_d;
      end
   end

   chk_st_e           fsm_q, fsm_d;
   logic [WIDTH-1:0]  chk_state_q, chk_state_d;
   logic [7:0]        seed_cnt_q, seed_cnt_d;
   logic [7:0]        match_q, match_d;
   logic [7:0]        loss_q, loss_d;
   logic              err_pulse_q, err_pulse_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

   logic [DATA_W-1:0] pred_word;
   logic [WIDTH-1:0]  pred_state, shifted;
   logic [6:0]        mism;
   logic [7:0]        seed_next;
   logic [ERR_W-1:0]  err_base;
   logic [SUM_W-1:0]  err_sum;
   logic              do_seed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm_q <= ST_SEARCH;
      else        fsm_q <= fsm_d;
   end

   always_comb begin
      pred_word   = lfsr_word(chk_state_q);
      pred_state  = lfsr_adv(chk_state_q);
      shifted     = shift_in(chk_state_q, chk_data);
      mism        = popcnt(chk_data ^ pred_word);
      seed_next   = ((fsm_q == ST_SEARCH) ? seed_cnt_q : 8'd0) + 8'd1;
      err_base    = err_clr ? '0 : err_cnt_q;
      err_sum     = SUM_W'(err_base) + SUM_W'(mism);
      fsm_d       = fsm_q;
      chk_state_d = chk_state_q;
      seed_cnt_d  = seed_cnt_q;
      match_d     = match_q;
      loss_d      = loss_q;
      err_pulse_d = 1'b0;
      err_cnt_d   = err_base;
      do_seed     = 1'b0;
      if (chk_valid) begin
         case (fsm_q)
            ST_SEARCH: do_seed = 1'b1;
            ST_VERIFY: begin
               if (chk_data == pred_word) begin
                  chk_state_d = pred_state;
                  match_d     = match_q + 8'd1;
                  if (match_q + 8'd1 >= LOCK_C) begin
                     fsm_d  = ST_LOCKED;
                     loss_d = '0;
                  end
               end else begin
                  do_seed = 1'b1;
               end
            end
            ST_LOCKED: begin
               chk_state_d = pred_state;
               if (mism != '0) begin
                  err_pulse_d = 1'b1;
                  err_cnt_d   = (err_sum[SUM_W-1:ERR_W] != '0) ? '1 : err_sum[ERR_W-1:0];
                  if (loss_q + 8'd1 >= LOSS_C) begin
                     fsm_d      = ST_SEARCH;
                     seed_cnt_d = '0;
                     match_d    = '0;
                     loss_d     = '0;
                  end else begin
                     loss_d = loss_q + 8'd1;
                  end
               end else begin
                  loss_d = '0;
               end
            end
            default: fsm_d = ST_SEARCH;
         endcase
      end
      // A VERIFY mismatch reuses the offending word as the first seed word.
      if (do_seed) begin
         chk_state_d = shifted;
         match_d     = '0;
         if (seed_next >= SEED_WORDS_C) begin
            seed_cnt_d = '0;
            fsm_d      = (shifted == '0) ? ST_SEARCH : ST_VERIFY;
         end else begin
            seed_cnt_d = seed_next;
            fsm_d      = ST_SEARCH;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_state_q <= '1;
         seed_cnt_q  <= '0;
         match_q     <= '0;
         loss_q      <= '0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         chk_state_q <= chk_state_d;
         seed_cnt_q  <= seed_cnt_d;
         match_q     <= match_d;
         loss_q      <= loss_d;
         err_pulse_q <= err_pulse_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   always_comb begin
      locked    = (fsm_q == ST_LOCKED);
      err_pulse = err_pulse_q;
      err_cnt   = err_cnt_q;
      gen_data  = gen_data_q;
      gen_valid = gen_valid_q;
   end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: loopback lock/error/loss table, reset, sequence and seeding.
module tb_prbs_gen_chk;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       seed_load;
   logic [6:0] seed;
   logic       gen_en;
   logic       chk_valid;
   logic [7:0] chk_data;
   logic       err_clr;

   logic [7:0]  gen_data, gen_data_s;
   logic        gen_valid, gen_valid_s;
   logic        locked, locked_s;
   logic        err_pulse, err_pulse_s;
   logic [15:0] err_cnt;
   logic [3:0]  err_cnt_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prbs_gen_chk u_dut (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .gen_en(gen_en),
      .gen_data(gen_data), .gen_valid(gen_valid), .chk_valid(chk_valid), .chk_data(chk_data),
      .err_clr(err_clr), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
   );

   prbs_gen_chk #(.ERR_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .gen_en(gen_en),
      .gen_data(gen_data_s), .gen_valid(gen_valid_s), .chk_valid(chk_valid), .chk_data(chk_data),
      .err_clr(err_clr), .locked(locked_s), .err_pulse(err_pulse_s), .err_cnt(err_cnt_s)
   );

   typedef struct {
      logic        ge;
      logic [7:0]  inj;
      logic        clr;
      logic        exp_lock;
      logic        exp_pulse;
      logic [15:0] exp_cnt;
      logic [3:0]  exp_sat;
   } vec_t;

   vec_t tbl[22];
   logic mb[0:1039];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bit-serial recurrence b[n] = b[n-7] ^ b[n-6]; first seven entries are the seed, MSB first.
   task automatic build_model(input logic [6:0] sd);
      for (int i = 0; i < 7; i++) mb[i] = sd[6-i];
      for (int n = 7; n < 1040; n++) mb[n] = mb[n-7] ^ mb[n-6];
   endtask

   function automatic logic [7:0] model_word(input int k);
      logic [7:0] w;
      for (int j = 0; j < 8; j++) w[7-j] = mb[7 + 8*k + j];
      return w;
   endfunction

   // Loopback: the checker receives the word the generator currently shows.
   task automatic cyc(input logic ge, input logic [7:0] inj, input logic clr);
      gen_en    = ge;
      chk_data  = gen_data ^ inj;
      chk_valid = gen_valid;
      err_clr   = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; seed_load = 1'b0; seed = '0; gen_en = 1'b0;
      chk_valid = 1'b0; chk_data = '0; err_clr = 1'b0;

      //            ge  inj    clr lock pulse cnt     sat
      tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  4'd0};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  4'd0};
      tbl[2]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  4'd0};
      tbl[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  4'd0};
      tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  4'd0};
      tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  4'd0};
      tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  4'd0};
      tbl[7]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  4'd0};
      tbl[8]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0,  4'd0};
      tbl[9]  = '{1'b1, 8'h09, 1'b0, 1'b1, 1'b1, 16'd2,  4'd2};
      tbl[10] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 16'd2,  4'd2};
      tbl[11] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 16'd1,  4'd1};
      tbl[12] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 16'd0,  4'd0};
      tbl[13] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 16'd8,  4'd8};
      tbl[14] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 16'd16, 4'd15};
      tbl[15] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 16'd24, 4'd15};
      tbl[16] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd24, 4'd15};
      tbl[17] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd24, 4'd15};
      tbl[18] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd24, 4'd15};
      tbl[19] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd24, 4'd15};
      tbl[20] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 16'd24, 4'd15};
      tbl[21] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 16'd24, 4'd15};

      #12;
      check("rst gen_data",  gen_data,  8'h00);
      check("rst gen_valid", gen_valid, 1'b0);
      check("rst locked",    locked,    1'b0);
      check("rst err_pulse", err_pulse, 1'b0);
      check("rst err_cnt",   err_cnt,   16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         cyc(tbl[i].ge, tbl[i].inj, tbl[i].clr);
         check($sformatf("row%0d locked", i),    locked,    tbl[i].exp_lock);
         check($sformatf("row%0d err_pulse", i), err_pulse, tbl[i].exp_pulse);
         check($sformatf("row%0d err_cnt", i),   err_cnt,   tbl[i].exp_cnt);
         check($sformatf("row%0d sat_cnt", i),   err_cnt_s, tbl[i].exp_sat);
      end

      // Asynchronous reset in the middle of a cycle.
      #2 rst_n = 1'b0;
      #1;
      check("async gen_data",  gen_data,  8'h00);
      check("async gen_valid", gen_valid, 1'b0);
      check("async locked",    locked,    1'b0);
      check("async err_pulse", err_pulse, 1'b0);
      check("async err_cnt",   err_cnt,   16'd0);
      check("async sat_cnt",   err_cnt_s, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 8'h00, 1'b0);
      check("pulse gen_valid", gen_valid, 1'b1);
      check("pulse gen_data",  gen_data,  8'h02);
      cyc(1'b0, 8'h00, 1'b0);
      check("hold gen_valid", gen_valid, 1'b0);
      check("hold gen_data",  gen_data,  8'h02);

      // Reseed to all ones while gen_en is high: seed_load wins.
      seed_load = 1'b1; seed = 7'h7F;
      cyc(1'b1, 8'h00, 1'b0);
      seed_load = 1'b0;
      check("seed prio gen_valid", gen_valid, 1'b0);
      check("seed prio gen_data",  gen_data,  8'h02);
      build_model(7'h7F);
      for (int k = 0; k < 128; k++) begin
         cyc(1'b1, 8'h00, 1'b0);
         check($sformatf("seq word%0d", k), gen_data, model_word(k));
         if (k == 0)   check("seq hand w0",  gen_data, 8'h02);
         if (k == 1)   check("seq hand w1",  gen_data, 8'h0C);
         if (k == 2)   check("seq hand w2",  gen_data, 8'h28);
         if (k == 127) check("seq period",   gen_data, 8'h02);
      end

      // All-zero seed behaves as all ones.
      seed_load = 1'b1; seed = 7'h00;
      cyc(1'b0, 8'h00, 1'b0);
      seed_load = 1'b0;
      cyc(1'b1, 8'h00, 1'b0);
      check("seed0 word0", gen_data, 8'h02);
      cyc(1'b1, 8'h00, 1'b0);
      check("seed0 word1", gen_data, 8'h0C);

      seed_load = 1'b1; seed = 7'h01;
      cyc(1'b0, 8'h00, 1'b0);
      seed_load = 1'b0;
      build_model(7'h01);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 8'h00, 1'b0);
         check($sformatf("seed1 word%0d", k), gen_data, model_word(k));
         if (k == 0) check("seed1 hand w0", gen_data, 8'h06);
      end
      cyc(1'b0, 8'h00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prbs_gen_chk.md
# prbs_gen_chk

Parametrised XOR-based pseudo-random bit sequence generator and self-synchronising checker, the sequential successor to the team's single XOR gate. Each clock, an unrolled Fibonacci LFSR produces DATA_W bits. An independent checker locks onto an incoming PRBS stream, counts bit errors and detects loss of lock. The block is used as a built-in test source and sink on the team's data links.

## Interface
- WIDTH, 7: LFSR length in bits (2..32).
- TAPS, 7'h60: feedback mask, WIDTH bits wide. Bit i set means s[i] enters the XOR. The default is x^7+x^6+1.
- DATA_W, 8: bits produced or checked per valid cycle (1..64).
- LOCK_WORDS, 4: consecutive matching words required to declare lock.
- LOSS_WORDS, 3: consecutive errored words that drop lock.
- ERR_W, 16: error counter width.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- seed_load  in  1  load `seed` into the generator LFSR.
- seed  in  WIDTH  generator seed.
- gen_en  in  1  advance the generator by one word.
- gen_data  out  DATA_W  generated word; bit DATA_W-1 is first in time.
- gen_valid  out  1  gen_data is new this cycle.
- chk_valid  in  1  chk_data is valid.
- chk_data  in  DATA_W  received word; bit DATA_W-1 is first in time.
- err_clr  in  1  clear err_cnt.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  the last accepted word had at least one bit error while LOCKED.
- err_cnt  out  ERR_W  accumulated bit errors, saturating.

## Operation
- LFSR step: new = XOR of s[i] for every i with TAPS[i]=1.
  - Next state: s <= {s[WIDTH-2:0], new}.
  - The output bit is `new`.
  - One word is DATA_W steps. The first step drives gen_data[DATA_W-1].
- Generator:
  - seed_load has priority over gen_en. It sets s <= seed, and an all-zero seed is replaced by all ones. gen_valid is 0 in the following cycle.
  - gen_en=1 with seed_load=0: gen_data <= next word, state advances, gen_valid <= 1.
  - gen_en=0: gen_valid <= 0. gen_data and the state hold.
- Checker state machine (SEARCH, VERIFY, LOCKED). A cycle with chk_valid=0 changes nothing.
  - SEARCH:
    - Each valid word's bits are shifted into the checker state in time order; the newest bit goes to bit 0.
    - The block counts bits received. Once ceil(WIDTH/DATA_W) words have been received, it moves to VERIFY with match count 0.
    - An all-zero loaded state stays in SEARCH and the bit count restarts.
  - VERIFY:
    - Each valid word is compared with the predicted next word.
    - A match increments the match count and advances the state. When the count reaches LOCK_WORDS the checker goes to LOCKED.
    - A mismatch returns to SEARCH, and that word counts as the first seed word.
  - LOCKED:
    - The state advances on predicted bits (flywheel); received bits never reseed it.
    - For each word, mismatches = popcount(chk_data XOR predicted).
    - err_cnt += mismatches, saturating at 2^ERR_W-1.
    - err_pulse is high for one cycle per errored word.
    - LOSS_WORDS consecutive errored words move the checker to SEARCH, with bit count 0 and locked dropping. A clean word resets the loss count.
- err_clr: err_cnt <= 0. If an errored word arrives in the same cycle, err_cnt <= mismatches of that word (clear, then add).
- err_cnt persists across loss of lock and relock. It is reset only by rst_n or err_clr.

## Timing
- Reset values:
  - Generator state all ones.
  - Checker state all ones, bit count 0, match count 0, loss count 0.
  - gen_data=0, gen_valid=0, FSM=SEARCH, locked=0, err_pulse=0, err_cnt=0.
- Generator latency is 1 cycle: gen_en sampled at edge n gives gen_valid/gen_data after edge n.
- gen_en held high produces one word per cycle with no bubbles.
- Checker outputs are registered and update at the edge that samples the word.
- With default parameters, locked rises after the 5th consecutive valid clean word: 1 seed word plus 4 verify words.
- Deasserting rst_n mid-operation returns every output to its reset value immediately (asynchronously).
- Sequence period is 2^WIDTH-1 bits for primitive TAPS. The default gives 127.

## Test plan
- Reset: drive rst_n=0 mid-stream -> all outputs at reset values within the same cycle. Release, pulse gen_en once -> gen_valid=1 for 1 cycle and gen_data=8'h02. This is the default LFSR, reset state all ones.
- Sequence: gen_en high for 127 cycles -> 1016 bits match a software LFSR model. The 7-bit state returns to 7'h7F every 127 bits. seed_load with seed=0 gives the same output as seed=7'h7F.
- Loopback lock: gen_data/gen_valid feed chk_data/chk_valid -> locked=1 after the 5th valid word, err_cnt=0. Insert chk_valid gaps -> lock timing counts valid words only.
- Error injection: while locked, flip bits 0 and 3 of one word -> err_pulse high for exactly 1 cycle, err_cnt=2, locked stays 1. err_clr in the same cycle as a 1-bit error -> err_cnt=1.
- Loss and relock: invert 3 consecutive words -> locked=0 after the 3rd, err_cnt=24. Clean words follow -> locked=1 again after 5 words.
- Saturation: ERR_W=4, feed an inverted stream while locked until the count saturates -> err_cnt holds at 15 and does not wrap.
